mw_carry_chain_alu: RTL and testbench

- Multi-word add/subtract sequencer for the ALU datapath.
- Consumes the carry-out side of the adder: captures carry-out into a persistent carry flag and feeds it back as carry-in for chained (ADC/SBC) operations.
- Processes one W-bit slice per clock, LSB slice first, over WORDS cycles.
- Operands arrive and results leave through ready/valid handshakes.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/mw_carry_chain_alu_if.sv | 37 +++
 rtl/slice_adder.sv | 19 +
 rtl/mw_carry_chain_alu.sv | 164 ++++++++++++++++
 tb/tb_mw_carry_chain_alu.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation and sequencer state encodings, plus the
// carry-in selection used by both the ALU and the multi-word sequencer.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Carry-in for the first slice: plain ops start fresh (0 for add, 1 for
   // two's-complement subtract), chained ops continue from the carry flag.
   function automatic logic init_carry(op_e op, logic cflag);
      logic cin;
      case (op)
         OP_ADD:  cin = 1'b0;
         OP_SUB:  cin = 1'b1;
         OP_ADC:  cin = cflag;
         OP_SBC:  cin = cflag;
         default: cin = 1'b0;
      endcase
      return cin;
   endfunction

   // Subtract variants feed the adder with inverted B.
   function automatic logic op_inverts(op_e op);
      return (op == OP_SUB) || (op == OP_SBC);
   endfunction

endpackage

// File: rtl/mw_carry_chain_alu_if.sv
// Request/response bundle of the multi-word ALU sequencer. The master side
// issues operations and consumes results; the slave side is the sequencer.
interface mw_carry_chain_alu_if #(
   parameter int W     = 8,
   parameter int WORDS = 4
);
   import alu_pkg::*;

   localparam int N = W * WORDS;

   logic         start_valid;
   logic         start_ready;
   op_e          op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         clr_carry;
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] result;
   logic         carry_flag;
   logic         zero_flag;
   logic         neg_flag;
   logic         ovf_flag;

   modport master (
      output start_valid, op, a, b, clr_carry, res_ready,
      input  start_ready, res_valid, result,
             carry_flag, zero_flag, neg_flag, ovf_flag
   );

   modport slave (
      input  start_valid, op, a, b, clr_carry, res_ready,
      output start_ready, res_valid, result,
             carry_flag, zero_flag, neg_flag, ovf_flag
   );

endinterface

// File: rtl/slice_adder.sv
// One W-bit adder pass with optional B inversion; the sequencer reuses this
// single instance for every slice of a multi-word operation.
module slice_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         inv,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         co
);

   // (W+1)-bit sum so the top bit is the carry-out of the slice.
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b ^ {W{inv}}} + {{W{1'b0}}, cin};
   end

endmodule

// File: rtl/mw_carry_chain_alu.sv
// Multi-word add/subtract sequencer. Walks the operands one W-bit slice per
// clock (LSB first) through a shared slice adder, chaining the carry between
// slices and into a persistent carry flag for ADC/SBC.
module mw_carry_chain_alu
   import alu_pkg::*;
#(
   parameter int W     = 8,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mw_carry_chain_alu_if.slave   bus
);

   localparam int N     = W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic             inv_q, inv_d;
   logic             c_q, c_d;
   logic             zacc_q, zacc_d;
   logic [N-1:0]     result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             res_valid_q, res_valid_d;

   logic [W-1:0]     a_sl;
   logic [W-1:0]     b_sl;
   logic [W-1:0]     sum_s;
   logic             sum_co;

   // Select the operand slices addressed by the current slice index.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_sl = a_q[k*W +: W];
            b_sl = b_q[k*W +: W];
         end
      end
   end

   slice_adder #(.W(W)) u_slice_adder (
      .a   (a_sl),
      .b   (b_sl),
      .inv (inv_q),
      .cin (c_q),
      .s   (sum_s),
      .co  (sum_co)
   );

   // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      inv_d       = inv_q;
      c_d         = c_q;
      zacc_d      = zacc_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;
      res_valid_d = res_valid_q;

      case (state_q)
         S_IDLE: begin
            if (bus.clr_carry) begin
               carry_d = 1'b0;
            end
            if (bus.start_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               inv_d   = op_inverts(bus.op);
               // A same-cycle clear beats the stored carry for chained ops.
               c_d     = init_carry(bus.op, carry_q & ~bus.clr_carry);
               idx_d   = '0;
               zacc_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int k = 0; k < WORDS; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  result_d[k*W +: W] = sum_s;
               end
            end
            c_d    = sum_co;
            zacc_d = zacc_q & (sum_s == '0);
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               carry_d     = sum_co;
               zero_d      = zacc_q & (sum_s == '0);
               neg_d       = sum_s[W-1];
               ovf_d       = (a_q[N-1] == (b_q[N-1] ^ inv_q)) &&
                             (sum_s[W-1] != a_q[N-1]);
               res_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         inv_q       <= 1'b0;
         c_q         <= 1'b0;
         zacc_q      <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         inv_q       <= inv_d;
         c_q         <= c_d;
         zacc_q      <= zacc_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus.start_ready = (state_q == S_IDLE);
   assign bus.res_valid   = res_valid_q;
   assign bus.result      = result_q;
   assign bus.carry_flag  = carry_q;
   assign bus.zero_flag   = zero_q;
   assign bus.neg_flag    = neg_q;
   assign bus.ovf_flag    = ovf_q;

endmodule

// File: tb/tb_mw_carry_chain_alu.sv
// Bench for the multi-word ALU sequencer: directed scenarios followed by
// random operations, all compared against an arithmetic reference model.
module tb_mw_carry_chain_alu;
   import alu_pkg::*;

   localparam int W     = 8;
   localparam int WORDS = 4;
   localparam int N     = W * WORDS;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_err;

   // Reference carry flag as seen by the model.
   logic cf_m;

   mw_carry_chain_alu_if #(.W(W), .WORDS(WORDS)) bus ();

   mw_carry_chain_alu #(.W(W), .WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain-arithmetic model of one operation.
   task automatic model(input op_e op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic clr,
                        output logic [N-1:0] r, output logic c,
                        output logic z, output logic n, output logic v);
      longint ua, ub, sa, sb, full, sfull;
      longint cin;
      logic   cflag;
      cflag = clr ? 1'b0 : cf_m;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_ADD:  cin = 0;
         OP_SUB:  cin = 1;
         default: cin = cflag ? 1 : 0;
      endcase
      if (op == OP_ADD || op == OP_ADC) begin
         full  = ua + ub + cin;
         c     = (full >= 64'sh1_0000_0000);
         sfull = sa + sb + cin;
      end else begin
         full  = ua - ub - (1 - cin);
         c     = (full >= 0);
         sfull = sa - sb - (1 - cin);
      end
      r = full[N-1:0];
      z = (r == '0);
      n = r[N-1];
      v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_start_ready"}, 64'(bus.start_ready), 64'd1);
      check_eq({tag, "_res_valid"},   64'(bus.res_valid),   64'd0);
      check_eq({tag, "_result"},      64'(bus.result),      64'd0);
      check_eq({tag, "_carry"},       64'(bus.carry_flag),  64'd0);
      check_eq({tag, "_zero"},        64'(bus.zero_flag),   64'd0);
      check_eq({tag, "_neg"},         64'(bus.neg_flag),    64'd0);
      check_eq({tag, "_ovf"},         64'(bus.ovf_flag),    64'd0);
   endtask

   task automatic check_result(input string tag, input logic [N-1:0] r,
                               input logic c, input logic z, input logic n,
                               input logic v);
      check_eq({tag, "_res_valid"}, 64'(bus.res_valid),  64'd1);
      check_eq({tag, "_result"},    64'(bus.result),     64'(r));
      check_eq({tag, "_carry"},     64'(bus.carry_flag), 64'(c));
      check_eq({tag, "_zero"},      64'(bus.zero_flag),  64'(z));
      check_eq({tag, "_neg"},       64'(bus.neg_flag),   64'(n));
      check_eq({tag, "_ovf"},       64'(bus.ovf_flag),   64'(v));
   endtask

   // Issue one operation, hold res_ready low for 'hold' DONE cycles, and
   // check latency, busy signalling, result, flags and the drop of res_valid.
   task automatic do_op(input string tag, input op_e op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic clr, input int hold);
      logic [N-1:0] er;
      logic ec, ez, en, ev;
      int lat;
      model(op, a, b, clr, er, ec, ez, en, ev);
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.op          = op;
      bus.a           = a;
      bus.b           = b;
      bus.clr_carry   = clr;
      bus.res_ready   = (hold == 0);
      check_eq({tag, "_ready_idle"}, 64'(bus.start_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      bus.clr_carry   = 1'b0;
      bus.a           = N'($urandom);
      bus.b           = N'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            check_eq({tag, "_ready_busy"}, 64'(bus.start_ready), 64'd0);
         end
      end while (!bus.res_valid && lat < 20);
      check_eq({tag, "_latency"}, 64'(lat), 64'(WORDS));
      check_result(tag, er, ec, ez, en, ev);
      if (hold > 0) begin
         bus.start_valid = 1'b1;
         bus.op          = op_e'($urandom_range(0, 3));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_ready"}, 64'(bus.start_ready), 64'd0);
            check_result({tag, "_hold"}, er, ec, ez, en, ev);
         end
         bus.start_valid = 1'b0;
         bus.res_ready   = 1'b1;
      end
      @(posedge clk);
      #1;
      check_eq({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
      check_eq({tag, "_ready_back"}, 64'(bus.start_ready), 64'd1);
      cf_m = ec;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cf_m  = 1'b0;
      rst_n = 1'b0;
      bus.start_valid = 1'b0;
      bus.op          = OP_ADD;
      bus.a           = '0;
      bus.b           = '0;
      bus.clr_carry   = 1'b0;
      bus.res_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Plain add, carry between slices.
      do_op("add_ff_1", OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
      // Full wrap then chained add consumes the carry.
      do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      do_op("adc_chain", OP_ADC, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
      // Subtract: signed overflow, borrow, chained subtract.
      do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
      do_op("sub_borrow", OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
      do_op("sbc_chain", OP_SBC, 32'h0000_0005, 32'h0000_0001, 1'b0, 0);
      // Backpressure in DONE.
      do_op("add_bp", OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 3);
      // Clear beats a set carry flag on a chained op.
      do_op("add_set_c", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      do_op("adc_clr", OP_ADC, 32'h0000_0010, 32'h0000_0000, 1'b1, 0);

      // Reset during RUN, with the carry flag previously set.
      do_op("add_pre_rst", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.op          = OP_ADD;
      bus.a           = 32'hFFFF_FFFF;
      bus.b           = 32'h0000_0001;
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cf_m  = 1'b0;
      do_op("add_after_rst", OP_ADD, 32'h0000_0002, 32'h0000_0003, 1'b0, 0);

      // Random mix of operations, clears and backpressure.
      for (int i = 0; i < 40; i++) begin
         do_op("rand", op_e'($urandom_range(0, 3)), N'($urandom), N'($urandom),
               ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
